// File: rtl/rvv_backend_alu_pipe_pkg.sv
// Shared backend types for the ALU issue/execute/writeback slice:
// RS head-entry uop, PU-to-ROB result payload and the default lane count.
`ifndef NUM_ALU
`define NUM_ALU 2
`endif

package rvv_backend_alu_pipe_pkg;

  localparam int ROB_W  = 4;
  localparam int DATA_W = 16;

  // Opcodes the ALU understands; any other encoding yields no valid result.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_BAD = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [ROB_W-1:0]  rob_entry;
    alu_op_e           op;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
  } ALU_RS_t;

  typedef struct packed {
    logic [ROB_W-1:0]  rob_entry;
    logic [DATA_W-1:0] data;
  } PU2ROB_t;

endpackage

// File: rtl/rvv_backend_alu_stage.sv
// One-entry valid/ready output register for an ALU lane. A load while full
// is only issued when the entry drains in the same cycle, so no bubble.
module rvv_backend_alu_stage
  import rvv_backend_alu_pipe_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_flush,
  input  logic    i_load,
  input  PU2ROB_t i_data,
  input  logic    i_ready,
  output logic    o_valid,
  output PU2ROB_t o_data,
  output logic    o_can_acc
);

  logic    r_valid;
  PU2ROB_t r_data;

  // Valid bit: reset/flush win, then load, then drain on handshake.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Payload only changes on a load, so it holds steady under backpressure.
  always_ff @(posedge clk) begin
    if (i_load && !i_flush) begin
      r_data <= i_data;
    end
  end

  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_can_acc = !r_valid || i_ready;

endmodule

// File: rtl/rvv_backend_alu_unit.sv
// Combinational ALU lane: computes the result of one RS uop and reports
// whether the opcode produced a usable result.
module rvv_backend_alu_unit
  import rvv_backend_alu_pipe_pkg::*;
(
  input  logic    i_uop_valid,
  input  ALU_RS_t i_uop,
  output logic    o_result_valid,
  output PU2ROB_t o_result
);

  // Decode the opcode; unknown encodings leave result_valid low.
  always_comb begin
    o_result_valid     = 1'b0;
    o_result.rob_entry = i_uop.rob_entry;
    o_result.data      = '0;
    case (i_uop.op)
      ALU_ADD: begin o_result.data = i_uop.src1 + i_uop.src2; o_result_valid = i_uop_valid; end
      ALU_SUB: begin o_result.data = i_uop.src1 - i_uop.src2; o_result_valid = i_uop_valid; end
      ALU_AND: begin o_result.data = i_uop.src1 & i_uop.src2; o_result_valid = i_uop_valid; end
      ALU_OR:  begin o_result.data = i_uop.src1 | i_uop.src2; o_result_valid = i_uop_valid; end
      ALU_XOR: begin o_result.data = i_uop.src1 ^ i_uop.src2; o_result_valid = i_uop_valid; end
      default: ;
    endcase
  end

endmodule

// File: rtl/rvv_backend_alu_pipe.sv
// ALU execute pipe: NUM_LANE ALU units popping RS head entries in order,
// optionally registered before the ROB, with a sticky no-result error flag.
module rvv_backend_alu_pipe
  import rvv_backend_alu_pipe_pkg::*;
#(
  parameter int NUM_LANE = `NUM_ALU,
  parameter int OUT_REG  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_LANE-1:0]      uop_valid_rs2ex,
  input  ALU_RS_t [NUM_LANE-1:0]   alu_uop_rs2ex,
  output logic [NUM_LANE-1:0]      pop_ex2rs,
  input  logic                     flush,
  output logic [NUM_LANE-1:0]      result_valid_ex2rob,
  output PU2ROB_t [NUM_LANE-1:0]   result_ex2rob,
  input  logic [NUM_LANE-1:0]      result_ready_rob2alu,
  output logic                     err_uop
);

  logic [NUM_LANE-1:0] w_alu_valid;
  PU2ROB_t             w_alu_res [NUM_LANE];
  logic [NUM_LANE-1:0] w_can_acc;
  logic [NUM_LANE-1:0] w_stage_valid;
  PU2ROB_t             w_stage_data [NUM_LANE];
  logic [NUM_LANE-1:0] w_pop;
  logic [NUM_LANE-1:0] w_res_valid;
  logic                w_err_set;
  logic                r_err;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANE; gi++) begin : g_lane
      rvv_backend_alu_unit u_alu (
        .i_uop_valid    (uop_valid_rs2ex[gi]),
        .i_uop          (alu_uop_rs2ex[gi]),
        .o_result_valid (w_alu_valid[gi]),
        .o_result       (w_alu_res[gi])
      );

      if (OUT_REG != 0) begin : g_reg
        rvv_backend_alu_stage u_stage (
          .clk       (clk),
          .rst       (rst),
          .i_flush   (flush),
          .i_load    (w_pop[gi]),
          .i_data    (w_alu_res[gi]),
          .i_ready   (result_ready_rob2alu[gi]),
          .o_valid   (w_stage_valid[gi]),
          .o_data    (w_stage_data[gi]),
          .o_can_acc (w_can_acc[gi])
        );
      end else begin : g_comb
        assign w_stage_valid[gi] = 1'b0;
        assign w_stage_data[gi]  = '0;
        assign w_can_acc[gi]     = 1'b1;
      end

      assign result_ex2rob[gi] = (OUT_REG != 0) ? w_stage_data[gi] : w_alu_res[gi];
    end
  endgenerate

  // In-order pop chain: a lane is eligible only if every older lane pops.
  always_comb begin : p_pop
    logic v_prefix;
    logic v_lane_ok;
    w_pop       = '0;
    w_res_valid = '0;
    w_err_set   = 1'b0;
    v_prefix    = 1'b1;
    v_lane_ok   = 1'b0;
    for (int i = 0; i < NUM_LANE; i++) begin
      if (v_prefix && uop_valid_rs2ex[i] && !w_alu_valid[i]) begin
        w_err_set = 1'b1;
      end
      v_lane_ok = v_prefix & uop_valid_rs2ex[i] & w_alu_valid[i] & ~flush & ~rst;
      if (OUT_REG != 0) begin
        w_pop[i]       = v_lane_ok & w_can_acc[i];
        w_res_valid[i] = w_stage_valid[i] & ~rst;
      end else begin
        w_pop[i]       = v_lane_ok & result_ready_rob2alu[i];
        w_res_valid[i] = v_lane_ok;
      end
      v_prefix = w_pop[i];
    end
  end

  // Sticky error: an eligible uop that the ALU could not execute.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign pop_ex2rs           = w_pop;
  assign result_valid_ex2rob = w_res_valid;
  assign err_uop             = r_err;

`ifdef ASSERT_ON
  logic [NUM_LANE-1:0] r_hold;
  PU2ROB_t             r_hold_data [NUM_LANE];

  // Remember which lanes were stalled so the next cycle can check payload.
  always_ff @(posedge clk) begin
    r_hold <= result_valid_ex2rob & ~result_ready_rob2alu & ~{NUM_LANE{flush | rst}};
    for (int i = 0; i < NUM_LANE; i++) begin
      r_hold_data[i] <= result_ex2rob[i];
    end
  end

  // Thermometer inputs, contiguous pops and stable payload while stalled.
  always @(posedge clk) begin
    if (!rst) begin
      assert ((uop_valid_rs2ex & (uop_valid_rs2ex + 1'b1)) == '0)
        else $error("uop_valid_rs2ex not thermometer: %b", uop_valid_rs2ex);
      assert ((pop_ex2rs & (pop_ex2rs + 1'b1)) == '0)
        else $error("pop_ex2rs not prefix-contiguous: %b", pop_ex2rs);
      for (int i = 0; i < NUM_LANE; i++) begin
        if (OUT_REG != 0 && r_hold[i]) begin
          assert (result_valid_ex2rob[i] && result_ex2rob[i] == r_hold_data[i])
            else $error("lane %0d payload changed under backpressure", i);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rvv_backend_alu_pipe.sv
// Directed bench: a 2-lane registered pipe and a 4-lane combinational pipe.
module tb_rvv_backend_alu_pipe;
  import rvv_backend_alu_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 2-lane, registered outputs
  logic [1:0]      a_valid, a_pop, a_rv, a_ready;
  ALU_RS_t [1:0]   a_uop;
  PU2ROB_t [1:0]   a_res;
  logic            a_flush, a_err;

  // 4-lane, combinational outputs
  logic [3:0]      b_valid, b_pop, b_rv, b_ready;
  ALU_RS_t [3:0]   b_uop;
  PU2ROB_t [3:0]   b_res;
  logic            b_flush, b_err;

  rvv_backend_alu_pipe #(.NUM_LANE(2), .OUT_REG(1)) dut_a (
    .clk                  (clk),
    .rst                  (rst),
    .uop_valid_rs2ex      (a_valid),
    .alu_uop_rs2ex        (a_uop),
    .pop_ex2rs            (a_pop),
    .flush                (a_flush),
    .result_valid_ex2rob  (a_rv),
    .result_ex2rob        (a_res),
    .result_ready_rob2alu (a_ready),
    .err_uop              (a_err)
  );

  rvv_backend_alu_pipe #(.NUM_LANE(4), .OUT_REG(0)) dut_b (
    .clk                  (clk),
    .rst                  (rst),
    .uop_valid_rs2ex      (b_valid),
    .alu_uop_rs2ex        (b_uop),
    .pop_ex2rs            (b_pop),
    .flush                (b_flush),
    .result_valid_ex2rob  (b_rv),
    .result_ex2rob        (b_res),
    .result_ready_rob2alu (b_ready),
    .err_uop              (b_err)
  );

  int checks = 0;
  int errors = 0;

  ALU_RS_t     u_tab [16];
  logic [15:0] e_data [16];

  function automatic ALU_RS_t mk(input logic [3:0] r, input alu_op_e op,
                                 input logic [15:0] a, input logic [15:0] b);
    ALU_RS_t u;
    u.rob_entry = r;
    u.op        = op;
    u.src1      = a;
    u.src2      = b;
    return u;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    u_tab[0]  = mk(4'd0,  ALU_ADD, 16'h0003, 16'h0004); e_data[0]  = 16'h0007;
    u_tab[1]  = mk(4'd1,  ALU_SUB, 16'h0010, 16'h0001); e_data[1]  = 16'h000F;
    u_tab[2]  = mk(4'd2,  ALU_AND, 16'hF0F0, 16'h0FF0); e_data[2]  = 16'h00F0;
    u_tab[3]  = mk(4'd3,  ALU_OR,  16'hF000, 16'h000F); e_data[3]  = 16'hF00F;
    u_tab[4]  = mk(4'd4,  ALU_XOR, 16'hFFFF, 16'h1234); e_data[4]  = 16'hEDCB;
    u_tab[5]  = mk(4'd5,  ALU_ADD, 16'hFFFF, 16'h0002); e_data[5]  = 16'h0001;
    u_tab[6]  = mk(4'd6,  ALU_SUB, 16'h0000, 16'h0001); e_data[6]  = 16'hFFFF;
    u_tab[7]  = mk(4'd7,  ALU_XOR, 16'hAAAA, 16'h5555); e_data[7]  = 16'hFFFF;
    u_tab[8]  = mk(4'd8,  ALU_ADD, 16'h0001, 16'h0001); e_data[8]  = 16'h0002;
    u_tab[9]  = mk(4'd9,  ALU_ADD, 16'h0002, 16'h0002); e_data[9]  = 16'h0004;
    u_tab[10] = mk(4'd10, ALU_AND, 16'h00FF, 16'h0F0F); e_data[10] = 16'h000F;
    u_tab[11] = mk(4'd11, ALU_OR,  16'h0100, 16'h0010); e_data[11] = 16'h0110;
    u_tab[12] = mk(4'd12, ALU_SUB, 16'h0100, 16'h0001); e_data[12] = 16'h00FF;
    u_tab[13] = mk(4'd13, ALU_AND, 16'h1234, 16'h00FF); e_data[13] = 16'h0034;
    u_tab[14] = mk(4'd14, ALU_ADD, 16'h0005, 16'h0005); e_data[14] = 16'h000A;
    u_tab[15] = mk(4'd15, ALU_OR,  16'h0000, 16'h0000); e_data[15] = 16'h0000;

    rst = 1'b1;
    a_flush = 1'b0; a_valid = 2'b11; a_ready = 2'b11;
    a_uop[0] = u_tab[0]; a_uop[1] = u_tab[1];
    b_flush = 1'b0; b_valid = 4'b0000; b_ready = 4'b1111;
    for (int i = 0; i < 4; i++) b_uop[i] = u_tab[i];

    // Reset: pops and result valids held low, error flag cleared.
    step(); #3;
    chk("rst_pop_a", a_pop, 2'b00);
    chk("rst_rv_a", a_rv, 2'b00);
    chk("rst_err_a", a_err, 1'b0);
    chk("rst_err_b", b_err, 1'b0);
    step(); rst = 1'b0; a_valid = 2'b00; #3;
    chk("post_rst_rv_a", a_rv, 2'b00);

    // Full throughput: two pops per cycle, results one cycle later in order.
    for (int k = 0; k < 4; k++) begin
      step();
      a_valid = 2'b11; a_ready = 2'b11;
      a_uop[0] = u_tab[2*k]; a_uop[1] = u_tab[2*k+1];
      #3;
      chk($sformatf("tput_pop_%0d", k), a_pop, 2'b11);
      if (k > 0) begin
        chk($sformatf("tput_rv_%0d", k), a_rv, 2'b11);
        chk($sformatf("tput_rob0_%0d", k), a_res[0].rob_entry, 2*(k-1));
        chk($sformatf("tput_dat0_%0d", k), a_res[0].data, e_data[2*(k-1)]);
        chk($sformatf("tput_rob1_%0d", k), a_res[1].rob_entry, 2*(k-1)+1);
        chk($sformatf("tput_dat1_%0d", k), a_res[1].data, e_data[2*(k-1)+1]);
      end
    end
    step(); a_valid = 2'b00; #3;
    chk("tput_pop_end", a_pop, 2'b00);
    chk("tput_rv_last", a_rv, 2'b11);
    chk("tput_dat0_last", a_res[0].data, e_data[6]);
    chk("tput_rob1_last", a_res[1].rob_entry, 4'd7);
    step(); #3;
    chk("tput_drained", a_rv, 2'b00);

    // In-order blocking: lane 0 stalled blocks lane 1 even if it has room.
    step(); a_valid = 2'b11; a_ready = 2'b00;
    a_uop[0] = u_tab[8]; a_uop[1] = u_tab[9]; #3;
    chk("blk_load_pop", a_pop, 2'b11);
    step(); a_uop[0] = u_tab[10]; a_uop[1] = u_tab[11]; a_ready = 2'b10; #3;
    chk("blk_pop_1", a_pop, 2'b00);
    chk("blk_rv_1", a_rv, 2'b11);
    chk("blk_rob0_1", a_res[0].rob_entry, 4'd8);
    step(); #3;
    chk("blk_pop_2", a_pop, 2'b00);
    chk("blk_rv_2", a_rv, 2'b01);
    chk("blk_dat0_2", a_res[0].data, e_data[8]);
    step(); a_ready = 2'b11; #3;
    chk("blk_pop_3", a_pop, 2'b11);
    chk("blk_rob0_3", a_res[0].rob_entry, 4'd8);
    step(); a_valid = 2'b00; #3;
    chk("blk_rv_4", a_rv, 2'b11);
    chk("blk_dat0_4", a_res[0].data, e_data[10]);
    chk("blk_dat1_4", a_res[1].data, e_data[11]);
    step(); #3;
    chk("blk_drained", a_rv, 2'b00);

    // Flush with both stages full: pop suppressed, both valids dropped.
    step(); a_valid = 2'b11; a_ready = 2'b00;
    a_uop[0] = u_tab[12]; a_uop[1] = u_tab[13]; #3;
    chk("fl_load_pop", a_pop, 2'b11);
    step(); a_uop[0] = u_tab[14]; a_uop[1] = u_tab[15];
    a_flush = 1'b1; a_ready = 2'b01; #3;
    chk("fl_pop", a_pop, 2'b00);
    chk("fl_rv", a_rv, 2'b11);
    chk("fl_dat0", a_res[0].data, e_data[12]);
    step(); a_flush = 1'b0; a_valid = 2'b00; a_ready = 2'b11; #3;
    chk("fl_rv_after", a_rv, 2'b00);
    step(); #3;
    chk("fl_no_reissue", a_rv, 2'b00);

    // Uop the ALU cannot execute: no pop, sticky error.
    step(); a_valid = 2'b01; a_uop[0] = mk(4'd1, ALU_BAD, 16'h1, 16'h1); #3;
    chk("err_pop", a_pop, 2'b00);
    chk("err_before", a_err, 1'b0);
    step(); a_valid = 2'b00; #3;
    chk("err_set", a_err, 1'b1);
    chk("err_rv", a_rv, 2'b00);
    step(); step(); #3;
    chk("err_sticky", a_err, 1'b1);

    // Reset while lane 1 holds rob 5 under backpressure.
    step(); a_valid = 2'b11; a_ready = 2'b00;
    a_uop[0] = u_tab[4]; a_uop[1] = u_tab[5]; #3;
    chk("rr_load_pop", a_pop, 2'b11);
    step(); a_valid = 2'b00; a_ready = 2'b01; #3;
    chk("rr_rv_both", a_rv, 2'b11);
    step(); a_ready = 2'b00; #3;
    chk("rr_rv_hold", a_rv, 2'b10);
    chk("rr_rob1", a_res[1].rob_entry, 4'd5);
    chk("rr_dat1", a_res[1].data, e_data[5]);
    step(); rst = 1'b1; a_valid = 2'b11; a_uop[0] = u_tab[0]; a_uop[1] = u_tab[1]; #3;
    chk("rr_pop_in_rst", a_pop, 2'b00);
    chk("rr_rv_in_rst", a_rv, 2'b00);
    step(); rst = 1'b0; a_valid = 2'b00; a_ready = 2'b11; #3;
    chk("rr_rv_after", a_rv, 2'b00);
    chk("rr_err_cleared", a_err, 1'b0);
    step(); a_valid = 2'b11; #3;
    chk("rr_first_pop", a_pop, 2'b11);
    step(); a_valid = 2'b00; #3;
    chk("rr_rob0_new", a_res[0].rob_entry, 4'd0);
    chk("rr_rob1_new", a_res[1].rob_entry, 4'd1);

    // Combinational 4-lane pipe.
    step(); b_valid = 4'b0111; b_ready = 4'b1011; #3;
    chk("b_pop_0111", b_pop, 4'b0011);
    chk("b_rv_0111", b_rv, 4'b0111);
    chk("b_dat2", b_res[2].data, e_data[2]);
    step(); b_valid = 4'b1111; b_ready = 4'b1111; #3;
    chk("b_pop_all", b_pop, 4'b1111);
    chk("b_dat3", b_res[3].data, e_data[3]);
    step(); b_ready = 4'b1101; #3;
    chk("b_pop_stall1", b_pop, 4'b0001);
    chk("b_rv_stall1", b_rv, 4'b0011);
    step(); b_ready = 4'b1111; b_flush = 1'b1; #3;
    chk("b_pop_flush", b_pop, 4'b0000);
    chk("b_rv_flush", b_rv, 4'b0000);
    step(); b_flush = 1'b0; b_uop[1] = mk(4'd1, ALU_BAD, 16'h0, 16'h0); #3;
    chk("b_pop_bad", b_pop, 4'b0001);
    chk("b_rv_bad", b_rv, 4'b0001);
    chk("b_err_before", b_err, 1'b0);
    step(); b_valid = 4'b0000; #3;
    chk("b_err_set", b_err, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
